// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load extraction, writeback mux and
// architectural HI/LO. Define HILO_FWD_EN to bypass an in-flight HI/LO commit onto hi_out/lo_out.
module wb_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          stall,
   input  logic          flush,
   input  logic [1:0]    memToReg,
   input  logic          regwrite,
   input  logic          HI_read,
   input  logic          LO_read,
   input  logic          HI_write,
   input  logic          LO_write,
   input  logic [2:0]    ld_type,
   input  logic [1:0]    addr_lo,
   input  logic [DW-1:0] mem_data,
   input  logic [DW-1:0] pc,
   input  logic [DW-1:0] cp0_data,
   input  logic [DW-1:0] hi_in,
   input  logic [DW-1:0] lo_in,
   input  logic [RW-1:0] wdest,
   output logic          rf_we,
   output logic [RW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic [DW-1:0] hi_out,
   output logic [DW-1:0] lo_out,
   output logic          wb_valid
);

   localparam logic [2:0] LD_LB  = 3'b001;
   localparam logic [2:0] LD_LBU = 3'b010;
   localparam logic [2:0] LD_LH  = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;

   logic          valid_q, valid_d;
   logic [1:0]    mem_to_reg_q, mem_to_reg_d;
   logic          regwrite_q, regwrite_d;
   logic          hi_read_q, hi_read_d, lo_read_q, lo_read_d;
   logic          hi_write_q, hi_write_d, lo_write_q, lo_write_d;
   logic [2:0]    ld_type_q, ld_type_d;
   logic [1:0]    addr_lo_q, addr_lo_d;
   logic [DW-1:0] mem_data_q, mem_data_d;
   logic [DW-1:0] pc_q, pc_d;
   logic [DW-1:0] cp0_q, cp0_d;
   logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [RW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] hi_reg_q, hi_reg_d, lo_reg_q, lo_reg_d;

   logic          commit;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [DW-1:0] ld_data;

   assign commit   = valid_q & ~stall;
   assign in_ready = ~stall;

   always_comb begin
      valid_d      = valid_q;
      mem_to_reg_d = mem_to_reg_q;
      regwrite_d   = regwrite_q;
      hi_read_d    = hi_read_q;
      lo_read_d    = lo_read_q;
      hi_write_d   = hi_write_q;
      lo_write_d   = lo_write_q;
      ld_type_d    = ld_type_q;
      addr_lo_d    = addr_lo_q;
      mem_data_d   = mem_data_q;
      pc_d         = pc_q;
      cp0_d        = cp0_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      waddr_d      = waddr_q;
      hi_reg_d     = hi_reg_q;
      lo_reg_d     = lo_reg_q;
      // Stall beats flush: a flush seen while stalled is dropped and reissued upstream.
      if (!stall) begin
         valid_d      = in_valid & ~flush;
         mem_to_reg_d = memToReg;
         regwrite_d   = regwrite;
         hi_read_d    = HI_read;
         lo_read_d    = LO_read;
         hi_write_d   = HI_write;
         lo_write_d   = LO_write;
         ld_type_d    = ld_type;
         addr_lo_d    = addr_lo;
         mem_data_d   = mem_data;
         pc_d         = pc;
         cp0_d        = cp0_data;
         hi_d         = hi_in;
         lo_d         = lo_in;
         waddr_d      = wdest;
      end
      if (commit && hi_write_q) hi_reg_d = hi_q;
      if (commit && lo_write_q) lo_reg_d = lo_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         mem_to_reg_q <= '0;
         regwrite_q   <= 1'b0;
         hi_read_q    <= 1'b0;
         lo_read_q    <= 1'b0;
         hi_write_q   <= 1'b0;
         lo_write_q   <= 1'b0;
         ld_type_q    <= '0;
         addr_lo_q    <= '0;
         mem_data_q   <= '0;
         pc_q         <= '0;
         cp0_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         waddr_q      <= '0;
         hi_reg_q     <= '0;
         lo_reg_q     <= '0;
      end else begin
         valid_q      <= valid_d;
         mem_to_reg_q <= mem_to_reg_d;
         regwrite_q   <= regwrite_d;
         hi_read_q    <= hi_read_d;
         lo_read_q    <= lo_read_d;
         hi_write_q   <= hi_write_d;
         lo_write_q   <= lo_write_d;
         ld_type_q    <= ld_type_d;
         addr_lo_q    <= addr_lo_d;
         mem_data_q   <= mem_data_d;
         pc_q         <= pc_d;
         cp0_q        <= cp0_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         waddr_q      <= waddr_d;
         hi_reg_q     <= hi_reg_d;
         lo_reg_q     <= lo_reg_d;
      end
   end

   // Misaligned halfwords still use addr_lo[1]; the address exception is raised upstream.
   always_comb begin
      case (addr_lo_q)
         2'd0:    byte_sel = mem_data_q[7:0];
         2'd1:    byte_sel = mem_data_q[15:8];
         2'd2:    byte_sel = mem_data_q[23:16];
         default: byte_sel = mem_data_q[31:24];
      endcase
      half_sel = addr_lo_q[1] ? mem_data_q[31:16] : mem_data_q[15:0];
      case (ld_type_q)
         LD_LB:   ld_data = {{(DW-8){byte_sel[7]}}, byte_sel};
         LD_LBU:  ld_data = {{(DW-8){1'b0}}, byte_sel};
         LD_LH:   ld_data = {{(DW-16){half_sel[15]}}, half_sel};
         LD_LHU:  ld_data = {{(DW-16){1'b0}}, half_sel};
         default: ld_data = mem_data_q;
      endcase
   end

   always_comb begin
      case (mem_to_reg_q)
         2'b00:   rf_wdata = ld_data;
         2'b01:   rf_wdata = hi_read_q ? hi_reg_q : (lo_read_q ? lo_reg_q : '0);
         2'b10:   rf_wdata = pc_q + DW'(8);
         default: rf_wdata = cp0_q;
      endcase
   end

   assign rf_we    = valid_q & regwrite_q & (waddr_q != '0) & ~stall;
   assign rf_waddr = waddr_q;
   assign wb_valid = valid_q;

`ifdef HILO_FWD_EN
   assign hi_out = (commit && hi_write_q) ? hi_q : hi_reg_q;
   assign lo_out = (commit && lo_write_q) ? lo_q : lo_reg_q;
`else
   assign hi_out = hi_reg_q;
   assign lo_out = lo_reg_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for the writeback mux and load
// extraction, plus sequences for HI/LO commit, stall, flush and reset.
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, stall, flush;
   logic [1:0]  memToReg;
   logic        regwrite, HI_read, LO_read, HI_write, LO_write;
   logic [2:0]  ld_type;
   logic [1:0]  addr_lo;
   logic [31:0] mem_data, pc, cp0_data, hi_in, lo_in;
   logic [4:0]  wdest;
   logic        rf_we, wb_valid;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, hi_out, lo_out;

   int n_cmp = 0;
   int n_err = 0;

   wb_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .stall(stall), .flush(flush), .memToReg(memToReg), .regwrite(regwrite),
      .HI_read(HI_read), .LO_read(LO_read), .HI_write(HI_write), .LO_write(LO_write),
      .ld_type(ld_type), .addr_lo(addr_lo), .mem_data(mem_data), .pc(pc),
      .cp0_data(cp0_data), .hi_in(hi_in), .lo_in(lo_in), .wdest(wdest),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .hi_out(hi_out), .lo_out(lo_out), .wb_valid(wb_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  m2r;
      logic        rw;
      logic [2:0]  ld;
      logic [1:0]  al;
      logic [31:0] md;
      logic [31:0] pcv;
      logic [31:0] cp0;
      logic [4:0]  wd;
      logic        exp_we;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      in_valid = 0; stall = 0; flush = 0; memToReg = 0; regwrite = 0;
      HI_read = 0; LO_read = 0; HI_write = 0; LO_write = 0; ld_type = 0;
      addr_lo = 0; mem_data = 0; pc = 0; cp0_data = 0; hi_in = 0; lo_in = 0; wdest = 0;
   endtask

   int pulses;

   initial begin
      vecs[0]  = '{2'b00, 1, 3'b000, 2'd0, 32'h12345678, 32'h0, 32'h0, 5'd5,  1, 32'h12345678};
      vecs[1]  = '{2'b00, 1, 3'b001, 2'd2, 32'h80FF7F01, 32'h0, 32'h0, 5'd6,  1, 32'hFFFFFFFF};
      vecs[2]  = '{2'b00, 1, 3'b010, 2'd3, 32'h80FF7F01, 32'h0, 32'h0, 5'd7,  1, 32'h00000080};
      vecs[3]  = '{2'b00, 1, 3'b011, 2'd0, 32'h80FF7F01, 32'h0, 32'h0, 5'd8,  1, 32'h00007F01};
      vecs[4]  = '{2'b00, 1, 3'b100, 2'd2, 32'h80FF7F01, 32'h0, 32'h0, 5'd9,  1, 32'h000080FF};
      vecs[5]  = '{2'b00, 1, 3'b101, 2'd0, 32'h80FF7F01, 32'h0, 32'h0, 5'd10, 1, 32'h80FF7F01};
      vecs[6]  = '{2'b00, 1, 3'b011, 2'd3, 32'h80FF7F01, 32'h0, 32'h0, 5'd11, 1, 32'hFFFF80FF};
      vecs[7]  = '{2'b00, 1, 3'b001, 2'd1, 32'h80FF7F01, 32'h0, 32'h0, 5'd12, 1, 32'h0000007F};
      vecs[8]  = '{2'b10, 1, 3'b000, 2'd0, 32'h0, 32'h00400010, 32'h0, 5'd31, 1, 32'h00400018};
      vecs[9]  = '{2'b10, 1, 3'b000, 2'd0, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd31, 1, 32'h00000004};
      vecs[10] = '{2'b11, 1, 3'b101, 2'd0, 32'h11111111, 32'h0, 32'hCAFEF00D, 5'd14, 1, 32'hCAFEF00D};
      vecs[11] = '{2'b00, 1, 3'b000, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0,  0, 32'hDEADBEEF};

      // Reset with stall and in_valid asserted: reset must dominate.
      idle_inputs();
      rst = 1; stall = 1; in_valid = 1; regwrite = 1; wdest = 5'd9; mem_data = 32'h5;
      step(); step();
      chk("rst_wb_valid", {31'b0, wb_valid}, 0);
      chk("rst_rf_we", {31'b0, rf_we}, 0);
      chk("rst_rf_waddr", {27'b0, rf_waddr}, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_hi_out", hi_out, 0);
      chk("rst_lo_out", lo_out, 0);
      chk("in_ready_stalled", {31'b0, in_ready}, 0);
      idle_inputs();
      rst = 0;
      step();
      chk("idle_wb_valid", {31'b0, wb_valid}, 0);
      chk("in_ready_free", {31'b0, in_ready}, 1);

      for (int i = 0; i < 12; i++) begin
         in_valid = 1; memToReg = vecs[i].m2r; regwrite = vecs[i].rw; ld_type = vecs[i].ld;
         addr_lo = vecs[i].al; mem_data = vecs[i].md; pc = vecs[i].pcv;
         cp0_data = vecs[i].cp0; wdest = vecs[i].wd;
         step();
         chk($sformatf("vec%0d_we", i), {31'b0, rf_we}, {31'b0, vecs[i].exp_we});
         chk($sformatf("vec%0d_waddr", i), {27'b0, rf_waddr}, {27'b0, vecs[i].wd});
         chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
      end

      // MULT: both HI and LO commit at the end of its WB cycle.
      idle_inputs();
      in_valid = 1; HI_write = 1; LO_write = 1; hi_in = 32'hA; lo_in = 32'hB;
      step();
`ifdef HILO_FWD_EN
      chk("mult_fwd_hi", hi_out, 32'hA);
      chk("mult_fwd_lo", lo_out, 32'hB);
`else
      chk("mult_pre_hi", hi_out, 32'h0);
      chk("mult_pre_lo", lo_out, 32'h0);
`endif
      chk("mult_no_gpr", {31'b0, rf_we}, 0);
      HI_write = 0; LO_write = 0; memToReg = 2'b01; HI_read = 1; regwrite = 1; wdest = 5'd3;
      step();
      chk("mult_hi", hi_out, 32'hA);
      chk("mult_lo", lo_out, 32'hB);
      chk("mfhi_we", {31'b0, rf_we}, 1);
      chk("mfhi_wdata", rf_wdata, 32'hA);
      HI_read = 0; LO_read = 1; wdest = 5'd4;
      step();
      chk("mflo_wdata", rf_wdata, 32'hB);
      LO_read = 0;
      step();
      chk("mf_none_wdata", rf_wdata, 32'h0);

      // JAL held by a 3-cycle stall must write exactly once.
      idle_inputs();
      in_valid = 1; memToReg = 2'b10; regwrite = 1; pc = 32'h00400010; wdest = 5'd31;
      step();
      pulses = 0;
      in_valid = 0; pc = 32'h0; wdest = 5'd0; stall = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (rf_we) pulses++;
         step();
      end
      chk("jal_stall_valid", {31'b0, wb_valid}, 1);
      stall = 0;
      #1;
      if (rf_we) pulses++;
      chk("jal_wdata", rf_wdata, 32'h00400018);
      chk("jal_waddr", {27'b0, rf_waddr}, 31);
      step();
      if (rf_we) pulses++;
      chk("jal_pulses", pulses, 1);

      // Flushed MTHI: no HI commit, no live instruction.
      idle_inputs();
      in_valid = 1; flush = 1; HI_write = 1; hi_in = 32'h55;
      step();
      chk("flush_valid", {31'b0, wb_valid}, 0);
      idle_inputs();
      step();
      chk("flush_hi", hi_out, 32'hA);

      // Stall wins over flush: the held instruction stays live and writes once stall drops.
      in_valid = 1; regwrite = 1; wdest = 5'd7; mem_data = 32'h77;
      step();
      in_valid = 1; stall = 1; flush = 1; wdest = 5'd8; mem_data = 32'h88;
      step();
      chk("stflush_valid", {31'b0, wb_valid}, 1);
      chk("stflush_we", {31'b0, rf_we}, 0);
      idle_inputs();
      #1;
      chk("stflush_we2", {31'b0, rf_we}, 1);
      chk("stflush_waddr", {27'b0, rf_waddr}, 7);
      chk("stflush_wdata", rf_wdata, 32'h77);

      // MTLO stalled: LO must not commit until the stall lifts.
      in_valid = 1; LO_write = 1; lo_in = 32'h1234;
      step();
      idle_inputs();
      stall = 1;
      step();
      chk("stall_lo_hold", lo_out, 32'hB);
      stall = 0;
      step();
      chk("lo_commit", lo_out, 32'h1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
